// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed seven-segment display bus.
// Waits for each digit strobe to settle, decodes the segment pattern back to a
// hex nibble plus dot, and assembles a full frame of w_digit digits into a
// parallel number/dots word with a one-cycle frame_valid pulse.
module seven_segment_capture #(
    parameter int w_digit       = 2,
    parameter int settle_cycles = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             abcdefgh,
    input  logic [w_digit-1:0]     digit,
    output logic [w_digit*4-1:0]   number,
    output logic [w_digit-1:0]     dots,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic [w_digit-1:0]     captured
);

    localparam int                 CW      = $clog2(settle_cycles + 1);
    localparam logic [CW-1:0]      CNT_MAX = CW'(settle_cycles);
    localparam logic [CW-1:0]      CNT_PRE = CW'(settle_cycles - 1);
    localparam logic [w_digit-1:0] ALL_ONE = '1;

    // Inverse of the driver's segment table. Returns {bad, nibble}; any pattern
    // that the driver never produces (blank included) is flagged as bad and
    // reads back as nibble 0.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b1111110: res = 5'h00;
            7'b0110000: res = 5'h01;
            7'b1101101: res = 5'h02;
            7'b1111001: res = 5'h03;
            7'b0110011: res = 5'h04;
            7'b1011011: res = 5'h05;
            7'b1011111: res = 5'h06;
            7'b1110000: res = 5'h07;
            7'b1111111: res = 5'h08;
            7'b1110011: res = 5'h09;
            7'b1110111: res = 5'h0A;
            7'b0011111: res = 5'h0B;
            7'b1001110: res = 5'h0C;
            7'b0111101: res = 5'h0D;
            7'b1001111: res = 5'h0E;
            7'b1000111: res = 5'h0F;
            default:    res = 5'h10;
        endcase
        return res;
    endfunction

    // Registered copy of the bus; comparison against the live bus detects change.
    logic [7:0]           r_seg;
    logic [w_digit-1:0]   r_digit;

    // Stability counter and frame assembly state.
    logic [CW-1:0]        r_cnt;
    logic [w_digit*4-1:0] r_shadow_num;
    logic [w_digit-1:0]   r_shadow_dot;
    logic [w_digit-1:0]   r_captured;
    logic                 r_acc;
    logic                 r_pending;

    // Published frame.
    logic [w_digit*4-1:0] r_number;
    logic [w_digit-1:0]   r_dots;
    logic                 r_frame_valid;
    logic                 r_frame_err;

    logic                 w_same;
    logic                 w_capture;
    logic                 w_onehot;
    logic                 w_take;
    logic [4:0]           w_dec;
    logic [3:0]           w_nib;
    logic                 w_bad;
    logic [w_digit-1:0]   w_cap_next;
    logic                 w_done;

    // The capture fires only on the single edge where the counter reaches its
    // ceiling, so a bus held indefinitely is sampled exactly once.
    assign w_same     = ({abcdefgh, digit} == {r_seg, r_digit});
    assign w_capture  = w_same && (r_cnt == CNT_PRE);
    assign w_onehot   = (r_digit != '0) && ((r_digit & (r_digit - 1'b1)) == '0);
    assign w_take     = w_capture && w_onehot;
    assign w_dec      = decode_seg(r_seg[7:1]);
    assign w_nib      = w_dec[3:0];
    assign w_bad      = w_dec[4];
    assign w_cap_next = r_captured | r_digit;
    assign w_done     = w_take && (w_cap_next == ALL_ONE);

    // Sample the bus every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg   <= '0;
            r_digit <= '0;
        end else begin
            r_seg   <= abcdefgh;
            r_digit <= digit;
        end
    end

    // Count consecutive identical cycles, restarting on any change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_same) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Write the decoded digit into its shadow slot; repeats simply overwrite.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_num <= '0;
            r_shadow_dot <= '0;
        end else if (w_take) begin
            for (int i = 0; i < w_digit; i++) begin
                if (r_digit[i]) begin
                    r_shadow_num[i*4 +: 4] <= w_nib;
                    r_shadow_dot[i]        <= r_seg[0];
                end
            end
        end
    end

    // Track which digits have been seen and accumulate decode errors; a full
    // set arms publication on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_captured <= '0;
            r_acc      <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            if (r_pending) begin
                r_captured <= w_take ? r_digit : '0;
                r_acc      <= w_take & w_bad;
            end else if (w_take) begin
                r_captured <= w_cap_next;
                r_acc      <= r_acc | w_bad;
            end
            r_pending <= !r_pending && w_done;
        end
    end

    // Publish the assembled frame; outputs only move together with the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_number      <= '0;
            r_dots        <= '0;
            r_frame_err   <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= r_pending;
            if (r_pending) begin
                r_number    <= r_shadow_num;
                r_dots      <= r_shadow_dot;
                r_frame_err <= r_acc;
            end
        end
    end

    assign number      = r_number;
    assign dots        = r_dots;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign captured    = r_captured;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with w_digit=2, settle_cycles=4.
module tb_seven_segment_capture;

    logic       clk;
    logic       rst;
    logic [7:0] abcdefgh;
    logic [1:0] digit;
    logic [7:0] number;
    logic [1:0] dots;
    logic       frame_valid;
    logic       frame_err;
    logic [1:0] captured;

    int n_pass  = 0;
    int n_total = 0;
    int fv_count = 0;

    // Segment codes (abcdefgh, bit 0 = dot)
    localparam logic [7:0] SEG_3  = 8'b11110010;
    localparam logic [7:0] SEG_AD = 8'b11101111;
    localparam logic [7:0] SEG_8  = 8'b11111110;
    localparam logic [7:0] SEG_1  = 8'b01100000;
    localparam logic [7:0] SEG_5  = 8'b10110110;
    localparam logic [7:0] SEG_7  = 8'b11100000;
    localparam logic [7:0] SEG_C  = 8'b10011100;

    seven_segment_capture #(.w_digit(2), .settle_cycles(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .abcdefgh    (abcdefgh),
        .digit       (digit),
        .number      (number),
        .dots        (dots),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .captured    (captured)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_valid pulses as seen at each active edge.
    always @(posedge clk) if (frame_valid) fv_count <= fv_count + 1;

    task automatic drive_hold(input logic [7:0] seg, input logic [1:0] dig, input int n);
        abcdefgh = seg;
        digit    = dig;
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        rst      = 1'b1;
        abcdefgh = 8'h00;
        digit    = 2'b00;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(2);
        n_total++;
        if ({number, dots, frame_valid, frame_err, captured} !== 14'd0) begin
            $display("FAIL reset_state: got number=%h dots=%b fv=%b err=%b cap=%b, want all 0",
                     number, dots, frame_valid, frame_err, captured);
        end else n_pass++;
    endtask

    task automatic test_frame();
        int first  = -1;
        int pulses = 0;
        logic [7:0] num_s = 8'h00;
        logic [1:0] dot_s = 2'b00;
        logic       err_s = 1'b1;
        apply_reset(2);
        drive_hold(SEG_3, 2'b01, 8);
        abcdefgh = SEG_AD;
        digit    = 2'b10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (frame_valid) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    num_s = number;
                    dot_s = dots;
                    err_s = frame_err;
                end
            end
        end
        n_total++;
        if (first !== 6) $display("FAIL frame_latency: got cycle %0d, want 6", first);
        else n_pass++;
        n_total++;
        if (pulses !== 1) $display("FAIL frame_pulses: got %0d, want 1", pulses);
        else n_pass++;
        n_total++;
        if (num_s !== 8'hA3) $display("FAIL frame_number: got %h, want a3", num_s);
        else n_pass++;
        n_total++;
        if (dot_s !== 2'b10 || err_s !== 1'b0)
            $display("FAIL frame_dots_err: got dots=%b err=%b, want dots=10 err=0", dot_s, err_s);
        else n_pass++;
        n_total++;
        if (captured !== 2'b00 || number !== 8'hA3)
            $display("FAIL frame_hold: got cap=%b number=%h, want cap=00 number=a3", captured, number);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int base;
        apply_reset(2);
        base = fv_count;
        drive_hold(SEG_3, 2'b01, 2);
        drive_hold(SEG_8, 2'b01, 2);
        drive_hold(SEG_3, 2'b01, 4);
        n_total++;
        if (captured !== 2'b00) $display("FAIL glitch_early: got cap=%b, want 00", captured);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (captured !== 2'b01) $display("FAIL glitch_settle: got cap=%b, want 01", captured);
        else n_pass++;
        drive_hold(SEG_1, 2'b10, 8);
        n_total++;
        if (fv_count - base !== 1 || number !== 8'h13 || frame_err !== 1'b0 || dots !== 2'b00)
            $display("FAIL glitch_frame: got pulses=%0d number=%h err=%b dots=%b, want 1 13 0 00",
                     fv_count - base, number, frame_err, dots);
        else n_pass++;
    endtask

    task automatic test_invalid();
        int base;
        apply_reset(2);
        base = fv_count;
        drive_hold(8'h00, 2'b01, 8);
        drive_hold(SEG_1, 2'b10, 8);
        n_total++;
        if (fv_count - base !== 1 || number !== 8'h10 || frame_err !== 1'b1)
            $display("FAIL invalid_frame: got pulses=%0d number=%h err=%b, want 1 10 1",
                     fv_count - base, number, frame_err);
        else n_pass++;
        drive_hold(SEG_3, 2'b01, 8);
        drive_hold(SEG_AD, 2'b10, 8);
        n_total++;
        if (fv_count - base !== 2 || number !== 8'hA3 || frame_err !== 1'b0)
            $display("FAIL invalid_recover: got pulses=%0d number=%h err=%b, want 2 a3 0",
                     fv_count - base, number, frame_err);
        else n_pass++;
    endtask

    task automatic test_illegal_select();
        int base;
        apply_reset(2);
        base = fv_count;
        drive_hold(8'h00, 2'b11, 20);
        drive_hold(SEG_3, 2'b00, 20);
        n_total++;
        if (captured !== 2'b00 || fv_count - base !== 0)
            $display("FAIL illegal_select: got cap=%b pulses=%0d, want 00 0", captured, fv_count - base);
        else n_pass++;
        drive_hold(SEG_3, 2'b01, 8);
        drive_hold(SEG_AD, 2'b10, 8);
        n_total++;
        if (fv_count - base !== 1 || number !== 8'hA3 || frame_err !== 1'b0)
            $display("FAIL illegal_no_err: got pulses=%0d number=%h err=%b, want 1 a3 0",
                     fv_count - base, number, frame_err);
        else n_pass++;
    endtask

    task automatic test_overwrite();
        int base;
        apply_reset(2);
        base = fv_count;
        drive_hold(SEG_5, 2'b10, 8);
        drive_hold(SEG_5, 2'b00, 6);
        drive_hold(SEG_7, 2'b10, 8);
        n_total++;
        if (captured !== 2'b10 || fv_count - base !== 0)
            $display("FAIL overwrite_partial: got cap=%b pulses=%0d, want 10 0", captured, fv_count - base);
        else n_pass++;
        drive_hold(SEG_C, 2'b01, 8);
        n_total++;
        if (fv_count - base !== 1 || number !== 8'h7C || dots !== 2'b00 || frame_err !== 1'b0)
            $display("FAIL overwrite_frame: got pulses=%0d number=%h dots=%b err=%b, want 1 7c 00 0",
                     fv_count - base, number, dots, frame_err);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int base;
        drive_hold(SEG_3, 2'b01, 8);
        n_total++;
        if (captured !== 2'b01) $display("FAIL midframe_cap0: got cap=%b, want 01", captured);
        else n_pass++;
        apply_reset(1);
        n_total++;
        if ({number, dots, frame_valid, frame_err, captured} !== 14'd0)
            $display("FAIL midframe_reset: got number=%h dots=%b fv=%b err=%b cap=%b, want all 0",
                     number, dots, frame_valid, frame_err, captured);
        else n_pass++;
        base = fv_count;
        drive_hold(SEG_AD, 2'b10, 8);
        n_total++;
        if (fv_count - base !== 0 || captured !== 2'b10)
            $display("FAIL midframe_partial: got pulses=%0d cap=%b, want 0 10", fv_count - base, captured);
        else n_pass++;
        drive_hold(SEG_3, 2'b01, 8);
        n_total++;
        if (fv_count - base !== 1 || number !== 8'hA3 || dots !== 2'b10)
            $display("FAIL midframe_frame: got pulses=%0d number=%h dots=%b, want 1 a3 10",
                     fv_count - base, number, dots);
        else n_pass++;
    endtask

    initial begin
        rst      = 1'b1;
        abcdefgh = 8'h00;
        digit    = 2'b00;
        @(negedge clk);
        test_reset();
        test_frame();
        test_glitch();
        test_invalid();
        test_illegal_select();
        test_overwrite();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
